bandai_init_seq: RTL

BANDAI_INIT_SEQ -- requirements
Module: bandai_init_seq

---
 rtl/bandai_init_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/bandai_init_seq.sv
// Unlock, verify and bank-configure sequencer for a Bandai-style cartridge mapper.
// Define BANDAI_READBACK_EN to add a read-back verification pass after the bank writes.
module bandai_init_seq #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [31:0] BANK_IN,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [1:0]  ERR_CODE,
   output logic        CEn,
   output logic        WEn,
   output logic        OEn,
   output logic [7:0]  ADDR,
   output logic [7:0]  DQ_O,
   output logic        DQ_OE,
   input  logic [7:0]  DQ_I,
   input  logic        SO
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNLK0  = 3'd1;
   localparam logic [2:0] S_UNLK1  = 3'd2;
   localparam logic [2:0] S_SHIFT  = 3'd3;
   localparam logic [2:0] S_WR_ACT = 3'd4;
   localparam logic [2:0] S_WR_REL = 3'd5;
`ifdef BANDAI_READBACK_EN
   localparam logic [2:0] S_RD_ACT = 3'd6;
   localparam logic [2:0] S_RD_REL = 3'd7;
`endif

   localparam logic [7:0]  ADDR_UNLK0 = 8'h5A;
   localparam logic [7:0]  ADDR_UNLK1 = 8'hA5;
   localparam logic [17:0] UNLOCK_KEY = 18'h05140;
   localparam logic [4:0]  SHIFT_LAST = 5'd17;
   localparam logic [4:0]  WAIT_LAST  = 5'(WAIT_CYCLES - 1);
   localparam logic [1:0]  CODE_OK    = 2'b00;
   localparam logic [1:0]  CODE_KEY   = 2'b01;
`ifdef BANDAI_READBACK_EN
   localparam logic [1:0]  CODE_RB    = 2'b10;
`endif

   logic [2:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] bank_q, bank_d;
   logic [17:0] cap_q, cap_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
`ifdef BANDAI_READBACK_EN
   logic        rd_bad_q, rd_bad_d;
`else
   logic        unused_dq;
   assign unused_dq = ^DQ_I;
`endif

   logic [7:0] cur_byte;
   logic [7:0] bank_addr;

   assign cur_byte  = bank_q[{idx_q, 3'b000} +: 8];
   assign bank_addr = {6'b110000, idx_q};

   // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bank_d  = bank_q;
      cap_d   = cap_q;
      done_d  = 1'b0;
      err_d   = err_q;
      code_d  = code_q;
`ifdef BANDAI_READBACK_EN
      rd_bad_d = rd_bad_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_UNLK0;
               bank_d  = BANK_IN;
               cnt_d   = 5'd0;
               idx_d   = 2'd0;
               cap_d   = 18'd0;
               err_d   = 1'b0;
               code_d  = CODE_OK;
            end
         end
         S_UNLK0: state_d = S_UNLK1;
         S_UNLK1: begin
            state_d = S_SHIFT;
            cnt_d   = 5'd0;
         end
         S_SHIFT: begin
            // Serial ID arrives LSB first, so shift in from the top.
            cap_d = {SO, cap_q[17:1]};
            if (cnt_q == SHIFT_LAST) begin
               cnt_d = 5'd0;
               if (cap_d == UNLOCK_KEY) begin
                  state_d = S_WR_ACT;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  code_d  = CODE_KEY;
               end
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_WR_ACT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = 5'd0;
               state_d = S_WR_REL;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_WR_REL: begin
            if (idx_q == 2'd3) begin
               idx_d = 2'd0;
`ifdef BANDAI_READBACK_EN
               state_d = S_RD_ACT;
`else
               state_d = S_IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_WR_ACT;
            end
         end
`ifdef BANDAI_READBACK_EN
         S_RD_ACT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d    = 5'd0;
               rd_bad_d = (DQ_I != cur_byte);
               state_d  = S_RD_REL;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_RD_REL: begin
            // The release cycle always completes so the bus is idle when the sequence stops.
            if (rd_bad_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               code_d  = CODE_RB;
            end else if (idx_q == 2'd3) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_RD_ACT;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         idx_q    <= 2'd0;
         bank_q   <= 32'd0;
         cap_q    <= 18'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= CODE_OK;
`ifdef BANDAI_READBACK_EN
         rd_bad_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         bank_q   <= bank_d;
         cap_q    <= cap_d;
         done_q   <= done_d;
         err_q    <= err_d;
         code_q   <= code_d;
`ifdef BANDAI_READBACK_EN
         rd_bad_q <= rd_bad_d;
`endif
      end
   end

   // Bus outputs are a pure decode of state, so reset drives them idle immediately.
   always_comb begin
      ADDR  = 8'h00;
      DQ_O  = 8'h00;
      DQ_OE = 1'b0;
      CEn   = 1'b1;
      WEn   = 1'b1;
      OEn   = 1'b1;
      case (state_q)
         S_UNLK0: ADDR = ADDR_UNLK0;
         S_UNLK1: ADDR = ADDR_UNLK1;
         S_WR_ACT: begin
            ADDR  = bank_addr;
            DQ_O  = cur_byte;
            DQ_OE = 1'b1;
            CEn   = 1'b0;
            WEn   = 1'b0;
         end
         S_WR_REL: begin
            ADDR  = bank_addr;
            DQ_O  = cur_byte;
            DQ_OE = 1'b1;
         end
`ifdef BANDAI_READBACK_EN
         S_RD_ACT: begin
            ADDR = bank_addr;
            CEn  = 1'b0;
            OEn  = 1'b0;
         end
         S_RD_REL: ADDR = bank_addr;
`endif
         default: ;
      endcase
   end

   assign BUSY     = (state_q != S_IDLE);
   assign DONE     = done_q;
   assign ERR      = err_q;
   assign ERR_CODE = code_q;

endmodule
